moka_prog_loader: RTL and testbench

- Boot-time program loader sitting directly upstream of the core's instruction memory write port.
- Accepts a byte stream over a valid/ready handshake, parses a framed image, and assembles little-endian 32-bit words.
- Issues one-cycle instruction-memory writes (address, data, we) for each word and holds the core enable low until the image is fully written.
- The core's instr_mem_address, instr_mem_data, instr_mem_we and en inputs are driven from this block.

---
 rtl/moka_loader_pkg.sv | 27 ++
 rtl/moka_word_assembler.sv | 47 ++++
 rtl/moka_prog_loader.sv | 180 ++++++++++++++++++
 tb/tb_moka_prog_loader.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/moka_loader_pkg.sv
// Shared definitions for the moka program loader: FSM states, frame constants
// and the per-state byte-acceptance rule.
package moka_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CKSUM  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;
  localparam int         HDR_LEN       = 3;

  function automatic logic state_accepts(input state_e st);
    logic acc_s;
    case (st)
      ST_IDLE, ST_CNT_LO, ST_CNT_HI, ST_DATA, ST_CKSUM: acc_s = 1'b1;
      default:                                          acc_s = 1'b0;
    endcase
    return acc_s;
  endfunction

endpackage

// File: rtl/moka_word_assembler.sv
// Little-endian 4-byte word assembler: the first byte lands in bits 7:0 and a
// finished word is published with a one-cycle word_valid strobe.
module moka_word_assembler
  import moka_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_idx,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_idx_r;
  logic [23:0] shift_r;
  logic [31:0] word_r;
  logic        word_valid_r;

  // Shift bytes in and latch the completed word; word_r holds between writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx_r   <= 2'd0;
      shift_r      <= 24'd0;
      word_r       <= 32'd0;
      word_valid_r <= 1'b0;
    end else begin
      word_valid_r <= 1'b0;
      if (clr) begin
        byte_idx_r <= 2'd0;
      end else if (byte_valid) begin
        byte_idx_r <= byte_idx_r + 2'd1;
        shift_r    <= {byte_data, shift_r[23:8]};
        if (byte_idx_r == 2'd3) begin
          word_r       <= {byte_data, shift_r};
          word_valid_r <= 1'b1;
        end
      end
    end
  end

  assign byte_idx   = byte_idx_r;
  assign word_valid = word_valid_r;
  assign word       = word_r;

endmodule

// File: rtl/moka_prog_loader.sv
// Boot-time program loader: parses MAGIC/count/data frames into instruction
// memory writes and holds the core disabled until done. MOKA_LOADER_CKSUM_EN adds a trailing XOR checksum byte.
module moka_prog_loader
  import moka_loader_pkg::*;
#(
  parameter int         DATA_WIDTH   = 32,
  parameter int         MEM_CAPACITY = 1024,
  parameter logic [7:0] MAGIC        = DEFAULT_MAGIC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reload,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] instr_mem_address,
  output logic [DATA_WIDTH-1:0] instr_mem_data,
  output logic                  instr_mem_we,
  output logic                  core_en,
  output logic                  busy,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  state_e                state_r;
  logic [7:0]            cnt_lo_r;
  logic [15:0]           count_r;
  logic [15:0]           words_loaded_r;
  logic [DATA_WIDTH-1:0] addr_r;
  logic                  core_en_r;
  logic                  busy_r;
  logic                  error_r;
`ifdef MOKA_LOADER_CKSUM_EN
  logic [7:0]            xor_r;
`endif

  logic        in_ready_s;
  logic        accept_s;
  logic        byte_valid_s;
  logic        asm_clr_s;
  logic        word_done_s;
  logic        last_byte_s;
  logic [1:0]  byte_idx_s;
  logic        word_valid_s;
  logic [31:0] word_s;
  logic [15:0] count_s;

  // Reload blocks acceptance in its own cycle so nothing is consumed then
  assign in_ready_s   = state_accepts(state_r) & ~reload & ~rst;
  assign accept_s     = in_valid & in_ready_s;
  assign byte_valid_s = accept_s & (state_r == ST_DATA);
  assign asm_clr_s    = (state_r != ST_DATA);
  assign word_done_s  = byte_valid_s & (byte_idx_s == 2'd3);
  assign last_byte_s  = word_done_s & (words_loaded_r == (count_r - 16'd1));
  assign count_s      = {in_data, cnt_lo_r};

  moka_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr_s),
    .byte_valid (byte_valid_s),
    .byte_data  (in_data),
    .byte_idx   (byte_idx_s),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // Frame FSM with registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      cnt_lo_r       <= 8'd0;
      count_r        <= 16'd0;
      words_loaded_r <= 16'd0;
      addr_r         <= '0;
      core_en_r      <= 1'b0;
      busy_r         <= 1'b0;
      error_r        <= 1'b0;
`ifdef MOKA_LOADER_CKSUM_EN
      xor_r          <= 8'd0;
`endif
    end else if (reload) begin
      state_r   <= ST_IDLE;
      core_en_r <= 1'b0;
      busy_r    <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && (in_data == MAGIC)) begin
            state_r        <= ST_CNT_LO;
            words_loaded_r <= 16'd0;
            busy_r         <= 1'b1;
`ifdef MOKA_LOADER_CKSUM_EN
            xor_r          <= 8'd0;
`endif
          end
        end
        ST_CNT_LO: begin
          if (accept_s) begin
            cnt_lo_r <= in_data;
            state_r  <= ST_CNT_HI;
          end
        end
        ST_CNT_HI: begin
          if (accept_s) begin
            count_r <= count_s;
            if (count_s == 16'd0) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
            end else if (32'(count_s) > 32'(MEM_CAPACITY)) begin
              state_r <= ST_ERR;
              busy_r  <= 1'b0;
              error_r <= 1'b1;
            end else begin
              state_r <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
`ifdef MOKA_LOADER_CKSUM_EN
          if (byte_valid_s) begin
            xor_r <= xor_r ^ in_data;
          end
`endif
          // words_loaded doubles as the write address within the frame
          if (word_done_s) begin
            addr_r         <= DATA_WIDTH'(words_loaded_r);
            words_loaded_r <= words_loaded_r + 16'd1;
          end
          if (last_byte_s) begin
`ifdef MOKA_LOADER_CKSUM_EN
            state_r <= ST_CKSUM;
`else
            state_r <= ST_DONE;
`endif
          end
        end
`ifdef MOKA_LOADER_CKSUM_EN
        ST_CKSUM: begin
          if (accept_s) begin
            busy_r <= 1'b0;
            if (in_data == xor_r) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_ERR;
              error_r <= 1'b1;
            end
          end
        end
`endif
        ST_DONE: begin
          core_en_r <= 1'b1;
          busy_r    <= 1'b0;
        end
        ST_ERR: begin
          core_en_r <= 1'b0;
          busy_r    <= 1'b0;
          error_r   <= 1'b1;
        end
        default: begin
          state_r   <= ST_ERR;
          core_en_r <= 1'b0;
          busy_r    <= 1'b0;
          error_r   <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready          = in_ready_s;
  assign instr_mem_address = addr_r;
  assign instr_mem_data    = word_s;
  assign instr_mem_we      = word_valid_s;
  assign core_en           = core_en_r;
  assign busy              = busy_r;
  assign error             = error_r;
  assign words_loaded      = words_loaded_r;

endmodule

// File: tb/tb_moka_prog_loader.sv
// Self-checking bench for moka_prog_loader: directed frame table, corner
// sequences and randomized frames scored against a frame-level parser model.
`timescale 1ns/1ps
module tb_moka_prog_loader;
  import moka_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reload = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic [31:0] instr_mem_address;
  logic [31:0] instr_mem_data;
  logic        instr_mem_we;
  logic        core_en;
  logic        busy;
  logic        error;
  logic [15:0] words_loaded;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_we_cyc = -1;
  int en_rise_cyc = -1;
  int we_long = 0;
  int busy_viol = 0;
  logic we_prev = 1'b0;
  logic en_prev = 1'b0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  stim_q[$];
  bit          exp_done;
  bit          exp_err;
  int          exp_nw;

  typedef struct {
    int          nb;
    logic [95:0] b;
    int          exp_nw;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
    logic        exp_done;
    logic        exp_err;
    logic [15:0] exp_wl;
  } vec_t;
  vec_t vt[3];

  moka_prog_loader dut (
    .clk               (clk),
    .rst               (rst),
    .reload            (reload),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .instr_mem_address (instr_mem_address),
    .instr_mem_data    (instr_mem_data),
    .instr_mem_we      (instr_mem_we),
    .core_en           (core_en),
    .busy              (busy),
    .error             (error),
    .words_loaded      (words_loaded)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Passive write monitor sampled on the falling edge
  always @(negedge clk) begin
    if (instr_mem_we) begin
      wr_addr_q.push_back(instr_mem_address);
      wr_data_q.push_back(instr_mem_data);
      last_we_cyc = cyc;
      if (!busy) busy_viol++;
    end
    if (instr_mem_we && we_prev) we_long++;
    if (core_en && !en_prev) en_rise_cyc = cyc;
    we_prev = instr_mem_we;
    en_prev = core_en;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    last_we_cyc = -1;
    en_rise_cyc = -1;
  endtask

  // Starts and ends at posedge+1; gap idle cycles carry junk data with valid low
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: byte 0x%02h never accepted", b);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_end();
    int n = 0;
    @(negedge clk);
    while (!core_en && !error && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(core_en || error)) begin
      failures++;
      $display("FAIL end_timeout: core_en=%0b error=%0b", core_en, error);
    end
    @(posedge clk); #1;
  endtask

  // Reload while offering a MAGIC byte that must not be consumed
  task automatic do_reload();
    reload   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    chk("reload_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reload   = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("reload_core_en", core_en, 0);
    chk("reload_error", error, 0);
    chk("reload_busy", busy, 0);
    chk("reload_idle_ready", in_ready, 1);
    @(posedge clk); #1;
  endtask

  // Frame-level reference: find MAGIC, read count, slice 4-byte LE words
  task automatic model_run();
    int i = 0;
    int cnt;
    logic [7:0]  x = 8'd0;
    logic [31:0] w;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_nw   = 0;
    while (i < stim_q.size() && stim_q[i] != 8'hA5) i++;
    if (i + HDR_LEN > stim_q.size()) return;
    cnt = int'({stim_q[i+2], stim_q[i+1]});
    i += HDR_LEN;
    if (cnt == 0) exp_done = 1'b1;
    else if (cnt > 1024) exp_err = 1'b1;
    else begin
      for (int k = 0; k < cnt; k++) begin
        w = {stim_q[i+3], stim_q[i+2], stim_q[i+1], stim_q[i]};
        x = x ^ stim_q[i] ^ stim_q[i+1] ^ stim_q[i+2] ^ stim_q[i+3];
        exp_addr_q.push_back(32'(k));
        exp_data_q.push_back(w);
        exp_nw++;
        i += 4;
      end
`ifdef MOKA_LOADER_CKSUM_EN
      if (stim_q[i] == x) exp_done = 1'b1;
      else exp_err = 1'b1;
`else
      exp_done = 1'b1;
`endif
    end
  endtask

  task automatic run_stim(input string tag, input int gmin, input int gmax);
    int nmin;
    clear_mon();
    model_run();
    for (int k = 0; k < stim_q.size(); k++)
      send_byte(stim_q[k], int'($urandom_range(gmax, gmin)));
    wait_end();
    chk({tag, "_nwrites"}, wr_addr_q.size(), exp_addr_q.size());
    nmin = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
    for (int k = 0; k < nmin; k++) begin
      chk({tag, "_addr"}, wr_addr_q[k], exp_addr_q[k]);
      chk({tag, "_data"}, wr_data_q[k], exp_data_q[k]);
    end
    chk({tag, "_core_en"}, core_en, exp_done);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_words"}, words_loaded, exp_nw);
    chk({tag, "_ready"}, in_ready, 0);
    do_reload();
  endtask

  task automatic push_frame(input int cnt, input bit bad_ck);
    logic [7:0] x = 8'd0;
    logic [7:0] bt;
    stim_q.push_back(8'hA5);
    stim_q.push_back(cnt[7:0]);
    stim_q.push_back(cnt[15:8]);
    for (int k = 0; k < cnt * 4; k++) begin
      bt = 8'($urandom);
      x  = x ^ bt;
      stim_q.push_back(bt);
    end
`ifdef MOKA_LOADER_CKSUM_EN
    if (cnt > 0) stim_q.push_back(bad_ck ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
`else
    if (bad_ck) x = 8'd0;
`endif
  endtask

  initial begin
    logic [7:0] bt;
    logic [7:0] ck;
    int cnt;

    vt[0] = '{11, 96'hA502_0013_0000_0093_0010_0000, 2, 32'h0000_0013, 32'h0010_0093, 1'b1, 1'b0, 16'd2};
    vt[1] = '{5,  96'h00FF_A500_0000_0000_0000_0000, 0, 32'h0, 32'h0, 1'b1, 1'b0, 16'd0};
    vt[2] = '{3,  96'hA501_0400_0000_0000_0000_0000, 0, 32'h0, 32'h0, 1'b0, 1'b1, 16'd0};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_addr", instr_mem_address, 0);
    chk("rst_data", instr_mem_data, 0);
    chk("rst_we", instr_mem_we, 0);
    chk("rst_core_en", core_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_words", words_loaded, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed frame table
    for (int v = 0; v < 3; v++) begin
      clear_mon();
      ck = 8'd0;
      for (int k = 0; k < vt[v].nb; k++) begin
        bt = vt[v].b[95 - 8*k -: 8];
        if (k >= HDR_LEN) ck = ck ^ bt;
        send_byte(bt, 0);
      end
`ifdef MOKA_LOADER_CKSUM_EN
      if (vt[v].exp_nw > 0) send_byte(ck, 0);
`endif
      wait_end();
      chk("tbl_nwrites", wr_addr_q.size(), vt[v].exp_nw);
      if (vt[v].exp_nw > 0) begin
        chk("tbl_w0_addr", (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'hxxxx_xxxx, 32'd0);
        chk("tbl_w0_data", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hxxxx_xxxx, vt[v].exp_w0);
      end
      if (vt[v].exp_nw > 1) begin
        chk("tbl_w1_addr", (wr_addr_q.size() > 1) ? wr_addr_q[1] : 32'hxxxx_xxxx, 32'd1);
        chk("tbl_w1_data", (wr_data_q.size() > 1) ? wr_data_q[1] : 32'hxxxx_xxxx, vt[v].exp_w1);
        chk("tbl_hold_addr", instr_mem_address, 32'd1);
        chk("tbl_hold_data", instr_mem_data, vt[v].exp_w1);
`ifndef MOKA_LOADER_CKSUM_EN
        chk("tbl_core_en_timing", 32'(en_rise_cyc), 32'(last_we_cyc + 1));
`endif
      end
      chk("tbl_core_en", core_en, vt[v].exp_done);
      chk("tbl_error", error, vt[v].exp_err);
      chk("tbl_words", words_loaded, vt[v].exp_wl);
      chk("tbl_end_ready", in_ready, 0);
      do_reload();
      chk("tbl_words_kept", words_loaded, vt[v].exp_wl);
    end

    // count=1 with in_valid toggling every other cycle
    stim_q.delete();
    stim_q = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef MOKA_LOADER_CKSUM_EN
    stim_q.push_back(8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE);
`endif
    run_stim("toggle", 1, 1);

    // Asynchronous reset after two of four data bytes
    clear_mon();
    stim_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    for (int k = 0; k < stim_q.size(); k++) send_byte(stim_q[k], 0);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_words", words_loaded, 0);
    chk("mid_rst_core_en", core_en, 0);
    chk("mid_rst_data", instr_mem_data, 0);
    chk("mid_rst_nwrites", wr_addr_q.size(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    stim_q.delete();
    push_frame(2, 1'b0);
    run_stim("after_rst", 0, 0);

    // count == capacity is accepted and enters the data phase
    stim_q = '{8'hA5, 8'h00, 8'h04};
    for (int k = 0; k < stim_q.size(); k++) send_byte(stim_q[k], 0);
    @(negedge clk);
    chk("cap_busy", busy, 1);
    chk("cap_error", error, 0);
    chk("cap_ready", in_ready, 1);
    @(posedge clk); #1;
    do_reload();

`ifdef MOKA_LOADER_CKSUM_EN
    stim_q = '{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
    run_stim("ck_good", 0, 0);
    stim_q = '{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h45};
    run_stim("ck_bad", 0, 0);
`endif

    // Randomized frames with leading junk and random valid gaps
    for (int it = 0; it < 30; it++) begin
      stim_q.delete();
      for (int j = 0; j < int'($urandom_range(2, 0)); j++) begin
        bt = 8'($urandom);
        stim_q.push_back((bt == 8'hA5) ? 8'h5A : bt);
      end
      case ($urandom_range(9, 0))
        0: begin
          cnt = 1025 + int'($urandom_range(64510, 0));
          stim_q.push_back(8'hA5);
          stim_q.push_back(cnt[7:0]);
          stim_q.push_back(cnt[15:8]);
        end
        1: push_frame(0, 1'b0);
        default: push_frame(int'($urandom_range(5, 1)), ($urandom_range(3, 0) == 0));
      endcase
      run_stim("rnd", 0, 2);
    end

    chk("we_single_cycle", we_long, 0);
    chk("we_while_busy", busy_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
